// File: rtl/dot_prod_if.sv
// Control/bus bundle between a dot-product sequencer and its host, memories and MAC.
interface dot_prod_if;
    logic       start;
    logic       abort;
    logic [8:0] len;
    logic [7:0] a_base;
    logic [7:0] b_base;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic       mac_clr;
    logic       mac_en;
    logic       busy;
    logic       done;

    modport slave (
        input  start, abort, len, a_base, b_base,
        output addr_a, addr_b, mac_clr, mac_en, busy, done
    );

    modport master (
        output start, abort, len, a_base, b_base,
        input  addr_a, addr_b, mac_clr, mac_en, busy, done
    );
endinterface

// File: rtl/dot_prod_ctrl.sv
// Sequencer for an L-element dot product: walks two synchronous-read memories
// and steers a two-stage multiply-accumulator; every output is a flop.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | one cycle clearing the accumulator
// RUN   | issuing read addresses, one element per cycle
// DRAIN | two cycles letting the MAC product and accumulate stages settle
// DONE  | one-cycle done pulse, accumulator holds the result
module dot_prod_ctrl (
    input  logic      clk,
    input  logic      rst,
    dot_prod_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

    state_t     state_q, state_d;
    logic [8:0] k_q, k_d;
    logic [8:0] len_q, len_d;
    logic [7:0] a_base_q, a_base_d;
    logic [7:0] b_base_q, b_base_d;
    logic [7:0] addr_a_q, addr_a_d;
    logic [7:0] addr_b_q, addr_b_d;
    logic       drain_q, drain_d;
    logic       mac_clr_q, mac_clr_d;
    logic       mac_en_q, mac_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // rst is expected to be released synchronously to clk by the reset controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            len_q     <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            drain_q   <= 1'b0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_q     <= len_d;
            a_base_q  <= a_base_d;
            b_base_q  <= b_base_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            drain_q   <= drain_d;
            mac_clr_q <= mac_clr_d;
            mac_en_q  <= mac_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        len_d    = len_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        drain_d  = drain_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CLR;
                    len_d    = bus.len;
                    a_base_d = bus.a_base;
                    b_base_d = bus.b_base;
                    k_d      = '0;
                end
            end
            CLR: begin
                k_d     = '0;
                state_d = (len_q == 9'd0) ? DONE : RUN;
            end
            RUN: begin
                if (k_q == len_q - 9'd1) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            DRAIN: begin
                if (drain_q) state_d = DONE;
                else         drain_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort && (state_q != IDLE)) state_d = IDLE;

        // Outputs are registered decodes of the next state so they line up with it.
        mac_clr_d = (state_d == CLR);
        mac_en_d  = (state_q == RUN) && (state_d != IDLE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        addr_a_d  = (state_d == RUN) ? a_base_q + k_d[7:0] : addr_a_q;
        addr_b_d  = (state_d == RUN) ? b_base_q + k_d[7:0] : addr_b_q;
    end

    assign bus.addr_a  = addr_a_q;
    assign bus.addr_b  = addr_b_q;
    assign bus.mac_clr = mac_clr_q;
    assign bus.mac_en  = mac_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Bench for dot_prod_ctrl: directed operations push expected results into a queue,
// a negedge monitor pops and compares whenever done pulses.
module tb_dot_prod_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_prod_if bus ();

    dot_prod_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment: synchronous-read memories and a two-stage MAC.
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [7:0]  rd_a, rd_b;
    logic [15:0] prod;
    logic        prod_v = 1'b0;
    logic [31:0] acc;

    always @(posedge clk) begin
        rd_a <= mem_a[bus.addr_a];
        rd_b <= mem_b[bus.addr_b];
        if (bus.mac_clr) begin
            acc    <= '0;
            prod_v <= 1'b0;
        end else begin
            if (bus.mac_en) prod <= rd_a * rd_b;
            prod_v <= bus.mac_en;
            if (prod_v) acc <= acc + {16'd0, prod};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               start_edge;
        int               done_cyc;
        int               n_en;
        logic [31:0]      acc;
        logic [3:0][7:0]  ae;
        logic [3:0][7:0]  be;
        int               n_addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        else             n_pass++;
    endtask

    // Monitor
    int          obs_clr = 0;
    int          obs_en  = 0;
    int          obs_n   = 0;
    logic [7:0]  obs_a [4];
    logic [7:0]  obs_b [4];
    logic [7:0]  prev_a, prev_b;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (bus.mac_clr) begin
            obs_clr = cyc;
            obs_en  = 0;
            obs_n   = 0;
        end
        if (bus.mac_en) begin
            if (obs_n < 4) begin
                obs_a[obs_n] = prev_a;
                obs_b[obs_n] = prev_b;
            end
            obs_n++;
            obs_en++;
        end
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc - mon_e.start_edge + 1), 32'(mon_e.done_cyc));
                chk("clr_cycle", 32'(obs_clr - mon_e.start_edge + 1), 32'd1);
                chk("mac_en_count", 32'(obs_en), 32'(mon_e.n_en));
                chk("acc", acc, mon_e.acc);
                for (int i = 0; i < 4; i++) begin
                    if (i < mon_e.n_addr) begin
                        chk("addr_a_seq", 32'(obs_a[i]), 32'(mon_e.ae[i]));
                        chk("addr_b_seq", 32'(obs_b[i]), 32'(mon_e.be[i]));
                    end
                end
            end
        end
        prev_a = bus.addr_a;
        prev_b = bus.addr_b;
    end

    // Called at a negedge; returns #1 after the start-sampling edge.
    task automatic issue(input logic [8:0] l, input logic [7:0] ab, input logic [7:0] bb,
                         input int dc, input int ne, input logic [31:0] acc_e,
                         input logic [3:0][7:0] ae, input logic [3:0][7:0] be, input bit push);
        exp_t e;
        bus.start  = 1'b1;
        bus.len    = l;
        bus.a_base = ab;
        bus.b_base = bb;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        e.start_edge = cyc;
        e.done_cyc   = dc;
        e.n_en       = ne;
        e.acc        = acc_e;
        e.ae         = ae;
        e.be         = be;
        e.n_addr     = (l < 9'd4) ? int'(l) : 4;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL wait_done: no done within %0d cycles, expected one", budget);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    32'(bus.busy),    32'd0);
        chk({tag, "_done"},    32'(bus.done),    32'd0);
        chk({tag, "_mac_en"},  32'(bus.mac_en),  32'd0);
        chk({tag, "_mac_clr"}, 32'(bus.mac_clr), 32'd0);
        chk({tag, "_addr_a"},  32'(bus.addr_a),  32'd0);
        chk({tag, "_addr_b"},  32'(bus.addr_b),  32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.len    = '0;
        bus.a_base = '0;
        bus.b_base = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[8'h10 + i] = 8'(i + 1);
            mem_b[8'h20 + i] = 8'd2;
        end
        mem_a[8'hFE] = 8'd3; mem_a[8'hFF] = 8'd5; mem_a[8'h00] = 8'd7;
        mem_b[8'h40] = 8'd1; mem_b[8'h41] = 8'd2; mem_b[8'h42] = 8'd3;

        #1 rst = 1'b1;
        #1 chk_all_zero("reset");

        // First start on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        issue(9'd4, 8'h10, 8'h20, 8, 4, 32'd20, 32'h13121110, 32'h23222120, 1'b1);
        wait_done(50);

        // L=0 started in the IDLE cycle right after DONE.
        @(negedge clk);
        issue(9'd0, 8'h00, 8'h00, 2, 0, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_done(20);

        // Address wrap, with abort and start together in IDLE.
        @(negedge clk);
        bus.abort = 1'b1;
        issue(9'd3, 8'hFE, 8'h40, 7, 3, 32'd34, 32'h0000FFFE, 32'h00424140, 1'b1);
        bus.abort = 1'b0;
        wait_done(50);

        // L=256, all data 0xFF.
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        issue(9'd256, 8'h00, 8'h00, 260, 256, 32'h00FE0100, 32'h03020100, 32'h03020100, 1'b1);
        wait_done(400);

        // Abort in RUN k=2 of an L=8 run, then an L=1 run.
        @(negedge clk);
        mem_a[5] = 8'd6;
        mem_b[5] = 8'd7;
        issue(9'd8, 8'h00, 8'h80, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_busy",    32'(bus.busy),    32'd0);
        chk("abort_mac_en",  32'(bus.mac_en),  32'd0);
        chk("abort_mac_clr", 32'(bus.mac_clr), 32'd0);
        chk("abort_done",    32'(bus.done),    32'd0);
        chk("abort_addr_a",  32'(bus.addr_a),  32'h02);
        chk("abort_addr_b",  32'(bus.addr_b),  32'h82);
        @(negedge clk);
        issue(9'd1, 8'h05, 8'h05, 5, 1, 32'd42, 32'h05, 32'h05, 1'b1);
        wait_done(30);

        // Abort alone in IDLE does nothing.
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("idle_abort_busy", 32'(bus.busy), 32'd0);

        // Start pulses during RUN and during DONE are ignored.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mem_a[8'h30 + i] = 8'(i + 1);
            mem_b[8'h50 + i] = 8'd1;
        end
        issue(9'd5, 8'h30, 8'h50, 9, 5, 32'd15, 32'h33323130, 32'h53525150, 1'b1);
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.len    = 9'd2;
        bus.a_base = 8'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(50);
        bus.start = 1'b1;
        bus.len   = 9'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_in_done_busy", 32'(bus.busy), 32'd0);

        // Reset during DRAIN: outputs clear at once, no done afterwards.
        @(negedge clk);
        issue(9'd2, 8'h70, 8'h71, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("drain_mac_en_before_rst", 32'(bus.mac_en), 32'd1);
        rst = 1'b1;
        #1 chk_all_zero("rst_drain");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
